// File: rtl/mips_ifu_pkg.sv
// mips_ifu_pkg: shared encodings and widths for the MIPS fetch path
package mips_defs;
  localparam int W = 32;
  localparam logic [W-1:0] PC_RESET_DEF = 32'h0000_3000;
  typedef enum logic [1:0] {
    NPC_PC4 = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;
  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] FAULTED = 1'b1;
  function automatic logic [W-1:0] br_off(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction
endpackage

// File: rtl/mips_ifu_if.sv
// mips_ifu_if: decode-side controls into the fetch unit and fetch results back out
interface mips_ifu_if;
  import mips_defs::*;
  logic         stall;
  npc_sel_e     npc_sel;
  logic         br_taken;
  logic [15:0]  imm16;
  logic [25:0]  imm26;
  logic [W-1:0] rs_val;
  logic [W-1:0] pc;
  logic [W-1:0] pc4;
  logic [W-1:0] instr;
  logic [W-1:0] fetch_cnt;
  logic         pc_fault;
  modport master (
    output stall, npc_sel, br_taken, imm16, imm26, rs_val,
    input  pc, pc4, instr, fetch_cnt, pc_fault
  );
  modport slave (
    input  stall, npc_sel, br_taken, imm16, imm26, rs_val,
    output pc, pc4, instr, fetch_cnt, pc_fault
  );
endinterface

// File: rtl/mips_ifu_npc.sv
// mips_npc: combinational next-PC selection plus legality check against the ROM window
module mips_npc
  import mips_defs::*;
#(
  parameter logic [W-1:0] PC_RESET = PC_RESET_DEF,
  parameter int           IM_DEPTH = 4096
) (
  input  logic [W-1:0] pc,
  input  npc_sel_e     npc_sel,
  input  logic         br_taken,
  input  logic [15:0]  imm16,
  input  logic [25:0]  imm26,
  input  logic [W-1:0] rs_val,
  output logic [W-1:0] pc4,
  output logic [W-1:0] npc,
  output logic         legal
);
  localparam logic [W-1:0] SPAN = W'(4 * IM_DEPTH);
  logic [W-1:0] off;
  assign pc4 = pc + 32'd4;
  always_comb
    npc = npc_sel == NPC_PC4 ? pc4 :
          npc_sel == NPC_BR  ? (br_taken ? pc4 + br_off(imm16) : pc4) :
          npc_sel == NPC_J   ? {pc4[31:28], imm26, 2'b00} :
                               rs_val;
  // offset compare avoids overflow of PC_RESET + SPAN near the top of memory
  assign off   = npc - PC_RESET;
  assign legal = npc[1:0] == 2'b00 && npc >= PC_RESET && off < SPAN;
endmodule

// File: rtl/mips_ifu.sv
// mips_ifu: PC register, instruction ROM and next-PC commit with stall hold and sticky fault
module mips_ifu
  import mips_defs::*;
#(
  parameter logic [W-1:0] PC_RESET = PC_RESET_DEF,
  parameter int           IM_DEPTH = 4096,
  parameter string        IM_FILE  = "code.txt"
) (
  input  logic       clk,
  input  logic       reset,
  mips_ifu_if.slave  bus
);
  localparam int AW = IM_DEPTH > 1 ? $clog2(IM_DEPTH) : 1;
  localparam logic [W-1:0] SPAN = W'(4 * IM_DEPTH);
  logic [W-1:0]  rom [IM_DEPTH];
  logic [W-1:0]  pc, pc4, npc, cnt, off;
  logic [AW-1:0] idx;
  logic [0:0]    state;
  logic          legal;
  mips_npc #(.PC_RESET(PC_RESET), .IM_DEPTH(IM_DEPTH)) u_npc (
    .pc      (pc),
    .npc_sel (bus.npc_sel),
    .br_taken(bus.br_taken),
    .imm16   (bus.imm16),
    .imm26   (bus.imm26),
    .rs_val  (bus.rs_val),
    .pc4     (pc4),
    .npc     (npc),
    .legal   (legal)
  );
  assign off = pc - PC_RESET;
  assign idx = AW'(off >> 2);
  assign bus.pc        = pc;
  assign bus.pc4       = pc4;
  assign bus.instr     = pc >= PC_RESET && off < SPAN ? rom[idx] : '0;
  assign bus.fetch_cnt = cnt;
  assign bus.pc_fault  = state == FAULTED;
  // a rejected npc only raises the flag; later legal npcs keep fetching
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc    <= PC_RESET;
      cnt   <= '0;
      state <= RUN;
    end else if (!bus.stall) begin
      if (legal) begin
        pc  <= npc;
        cnt <= cnt + 32'd1;
      end else
        state <= FAULTED;
    end
endmodule

// File: tb/tb_mips_ifu.sv
// tb_mips_ifu: scoreboard bench for the fetch unit with a small known ROM image
module tb_mips_ifu;
  import mips_defs::*;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        flt;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  exp_t sbq[$];
  exp_t e;
  mips_ifu_if bus();
  mips_ifu #(.PC_RESET(32'h3000), .IM_DEPTH(64), .IM_FILE("")) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] a);
    logic [31:0] o;
    o = a - 32'h3000;
    return 32'h3400_0000 | (o >> 2);
  endfunction

  task automatic apply(input logic st, input npc_sel_e sel, input logic br, input logic [15:0] i16,
                       input logic [25:0] i26, input logic [31:0] rs,
                       input logic [31:0] epc, input logic [31:0] ecnt, input logic ef);
    bus.stall = st;
    bus.npc_sel = sel;
    bus.br_taken = br;
    bus.imm16 = i16;
    bus.imm26 = i26;
    bus.rs_val = rs;
    sbq.push_back('{pc: epc, cnt: ecnt, flt: ef});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #100 reset = 1'b0;
    #1;
    sbq.push_back('{pc: 32'h3000, cnt: 32'd0, flt: 1'b0});
    e = sbq.pop_front();
    checks++;
    if ({bus.pc, bus.pc4, bus.instr, bus.fetch_cnt, bus.pc_fault} !== {e.pc, e.pc + 32'd4, pat(e.pc), e.cnt, e.flt}) begin
      errors++;
      $display("FAIL reset_async: pc=%h cnt=%0d flt=%b instr=%h want pc=%h cnt=%0d flt=%b", bus.pc, bus.fetch_cnt, bus.pc_fault, bus.instr, e.pc, e.cnt, e.flt);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    sbq.push_back('{pc: 32'h3000, cnt: 32'd0, flt: 1'b0});
    e = sbq.pop_front();
    checks++;
    if ({bus.pc, bus.pc4, bus.instr, bus.fetch_cnt, bus.pc_fault} !== {e.pc, e.pc + 32'd4, pat(e.pc), e.cnt, e.flt}) begin
      errors++;
      $display("FAIL reset_release: pc=%h cnt=%0d flt=%b instr=%h want pc=%h cnt=%0d flt=%b", bus.pc, bus.fetch_cnt, bus.pc_fault, bus.instr, e.pc, e.cnt, e.flt);
    end
    apply(1'b0, NPC_PC4, 1'b0, 16'h0, 26'h0, 32'h0, 32'h3004, 32'd1, 1'b0);
    e = sbq.pop_front();
    checks++;
    if ({bus.pc, bus.pc4, bus.instr, bus.fetch_cnt, bus.pc_fault} !== {e.pc, e.pc + 32'd4, pat(e.pc), e.cnt, e.flt}) begin
      errors++;
      $display("FAIL first_fetch: pc=%h cnt=%0d flt=%b instr=%h want pc=%h cnt=%0d flt=%b", bus.pc, bus.fetch_cnt, bus.pc_fault, bus.instr, e.pc, e.cnt, e.flt);
    end
  endtask

  task automatic test_branch;
    npc_sel_e    sel[4] = '{NPC_PC4, NPC_BR, NPC_PC4, NPC_BR};
    logic        br[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] epc[4] = '{32'h3008, 32'h3004, 32'h3008, 32'h300C};
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, sel[i], br[i], 16'hFFFE, 26'h0, 32'h0, epc[i], 32'(2 + i), 1'b0);
      e = sbq.pop_front();
      checks++;
      if ({bus.pc, bus.pc4, bus.instr, bus.fetch_cnt, bus.pc_fault} !== {e.pc, e.pc + 32'd4, pat(e.pc), e.cnt, e.flt}) begin
        errors++;
        $display("FAIL branch[%0d]: pc=%h cnt=%0d flt=%b want pc=%h cnt=%0d flt=%b", i, bus.pc, bus.fetch_cnt, bus.pc_fault, e.pc, e.cnt, e.flt);
      end
    end
  endtask

  task automatic test_jump;
    npc_sel_e    sel[3] = '{NPC_PC4, NPC_J, NPC_JR};
    logic [31:0] epc[3] = '{32'h3010, 32'h3040, 32'h3018};
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, sel[i], 1'b0, 16'h0, 26'h0000C10, 32'h0000_3018, epc[i], 32'(6 + i), 1'b0);
      e = sbq.pop_front();
      checks++;
      if ({bus.pc, bus.pc4, bus.instr, bus.fetch_cnt, bus.pc_fault} !== {e.pc, e.pc + 32'd4, pat(e.pc), e.cnt, e.flt}) begin
        errors++;
        $display("FAIL jump[%0d]: pc=%h pc4=%h cnt=%0d want pc=%h pc4=%h cnt=%0d", i, bus.pc, bus.pc4, bus.fetch_cnt, e.pc, e.pc + 32'd4, e.cnt);
      end
    end
  endtask

  task automatic test_fault;
    npc_sel_e    sel[2] = '{NPC_JR, NPC_PC4};
    logic [31:0] epc[2] = '{32'h3018, 32'h301C};
    logic [31:0] ecn[2] = '{32'd8, 32'd9};
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, sel[i], 1'b0, 16'h0, 26'h0, 32'h0000_3002, epc[i], ecn[i], 1'b1);
      e = sbq.pop_front();
      checks++;
      if ({bus.pc, bus.pc4, bus.instr, bus.fetch_cnt, bus.pc_fault} !== {e.pc, e.pc + 32'd4, pat(e.pc), e.cnt, e.flt}) begin
        errors++;
        $display("FAIL fault[%0d]: pc=%h cnt=%0d flt=%b want pc=%h cnt=%0d flt=%b", i, bus.pc, bus.fetch_cnt, bus.pc_fault, e.pc, e.cnt, e.flt);
      end
    end
  endtask

  task automatic test_stall;
    logic        st[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    npc_sel_e    sel[5] = '{NPC_PC4, NPC_JR, NPC_J, NPC_PC4, NPC_PC4};
    logic [31:0] epc[5] = '{32'h3020, 32'h3020, 32'h3020, 32'h3020, 32'h3024};
    logic [31:0] ecn[5] = '{32'd10, 32'd10, 32'd10, 32'd10, 32'd11};
    for (int i = 0; i < 5; i++) begin
      apply(st[i], sel[i], 1'b0, 16'h0, 26'h0000C10, 32'h0000_3002, epc[i], ecn[i], 1'b1);
      e = sbq.pop_front();
      checks++;
      if ({bus.pc, bus.pc4, bus.instr, bus.fetch_cnt, bus.pc_fault} !== {e.pc, e.pc + 32'd4, pat(e.pc), e.cnt, e.flt}) begin
        errors++;
        $display("FAIL stall[%0d]: pc=%h instr=%h cnt=%0d want pc=%h instr=%h cnt=%0d", i, bus.pc, bus.instr, bus.fetch_cnt, e.pc, pat(e.pc), e.cnt);
      end
    end
  endtask

  task automatic test_midreset;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) apply(1'b0, NPC_J, 1'b0, 16'h0, 26'h0000C10, 32'h0, 32'h3040, 32'd12, 1'b1);
      if (i == 1) begin
        #2 reset = 1'b0;
        #1 sbq.push_back('{pc: 32'h3000, cnt: 32'd0, flt: 1'b0});
      end
      if (i == 2) begin
        @(negedge clk);
        reset = 1'b1;
        apply(1'b0, NPC_PC4, 1'b0, 16'h0, 26'h0, 32'h0, 32'h3004, 32'd1, 1'b0);
      end
      e = sbq.pop_front();
      checks++;
      if ({bus.pc, bus.pc4, bus.instr, bus.fetch_cnt, bus.pc_fault} !== {e.pc, e.pc + 32'd4, pat(e.pc), e.cnt, e.flt}) begin
        errors++;
        $display("FAIL midreset[%0d]: pc=%h cnt=%0d flt=%b want pc=%h cnt=%0d flt=%b", i, bus.pc, bus.fetch_cnt, bus.pc_fault, e.pc, e.cnt, e.flt);
      end
    end
  endtask

  task automatic test_boundary;
    npc_sel_e    sel[6] = '{NPC_JR, NPC_PC4, NPC_JR, NPC_JR, NPC_J, NPC_JR};
    logic [31:0] rs[6]  = '{32'h30FC, 32'h0, 32'h2FFC, 32'h3100, 32'h0, 32'h3000};
    logic [31:0] epc[6] = '{32'h30FC, 32'h30FC, 32'h30FC, 32'h30FC, 32'h30FC, 32'h3000};
    logic [31:0] ecn[6] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd3};
    logic        ef[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, sel[i], 1'b0, 16'h0, 26'h0, rs[i], epc[i], ecn[i], ef[i]);
      e = sbq.pop_front();
      checks++;
      if ({bus.pc, bus.pc4, bus.instr, bus.fetch_cnt, bus.pc_fault} !== {e.pc, e.pc + 32'd4, pat(e.pc), e.cnt, e.flt}) begin
        errors++;
        $display("FAIL boundary[%0d]: pc=%h cnt=%0d flt=%b want pc=%h cnt=%0d flt=%b", i, bus.pc, bus.fetch_cnt, bus.pc_fault, e.pc, e.cnt, e.flt);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) dut.rom[i] = 32'h3400_0000 | 32'(i);
    bus.stall = 1'b0;
    bus.npc_sel = NPC_PC4;
    bus.br_taken = 1'b0;
    bus.imm16 = 16'h0;
    bus.imm26 = 26'h0;
    bus.rs_val = 32'h0;
    test_reset();
    test_branch();
    test_jump();
    test_fault();
    test_stall();
    test_midreset();
    test_boundary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
